// File: rtl/diary_mem_writer.sv
// Purpose: packs a diary byte stream little-endian into 32-bit words and writes them linearly to external memory.
// Latency: byte accepted at edge N -> dwe=4'hF in cycle N+1 -> in_ready again in N+2 (N+3 with WRITE_VERIFY_EN).
// Backpressure: in_ready low while a word is being written (and verified) and permanently once full; optional read-back check under WRITE_VERIFY_EN.
module diary_mem_writer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          ADDR_W      = 12,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [31:0]       daddr,
  output logic [31:0]       dwdata,
  output logic [3:0]        dwe,
  input  logic [31:0]       drdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH_WORDS);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         lane;
  logic [31:0]        pack;
  logic [31:0]        merged;
  logic               accept;
  logic               flush;
  logic [ADDR_W:0]    count_inc;

  assign in_ready  = (state == IDLE) & ~full & ~reset;
  assign accept    = in_valid & in_ready;
  assign flush     = accept & (in_last | (lane == 2'd3));
  assign count_inc = word_count + (ADDR_W+1)'(1);

  // Merge the incoming byte into its lane of the pack register.
  always_comb begin
    merged = pack;
    case (lane)
      2'd0:    merged[7:0]   = in_data;
      2'd1:    merged[15:8]  = in_data;
      2'd2:    merged[23:16] = in_data;
      default: merged[31:24] = in_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: a completed or flushed word spends one cycle on the bus.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = WRITE;
`ifdef WRITE_VERIFY_EN
      WRITE:   state_nxt = VERIFY;
`else
      WRITE:   state_nxt = IDLE;
`endif
      VERIFY:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: byte packing, bus registers, pointer and fill tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      daddr      <= BASE_ADDR;
      dwdata     <= 32'h0;
      dwe        <= 4'h0;
      wr_ptr     <= '0;
      word_count <= '0;
      full       <= 1'b0;
      lane       <= 2'd0;
      pack       <= 32'h0;
    end else begin
      dwe <= 4'h0;
      if (accept) begin
        pack <= merged;
        lane <= lane + 2'd1;
        if (flush) begin
          // Unwritten lanes are still zero in merged, so partial words pad with zeros.
          daddr  <= BASE_ADDR | {{(32-ADDR_W){1'b0}}, wr_ptr};
          dwdata <= merged;
          dwe    <= 4'hF;
        end
      end
      if (state == WRITE) begin
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        word_count <= count_inc;
        full       <= (count_inc == DEPTH_C);
        lane       <= 2'd0;
        pack       <= 32'h0;
      end
    end
  end

`ifdef WRITE_VERIFY_EN
  // Sticky read-back check: daddr and dwdata still hold the word just written.
  always_ff @(posedge clk) begin
    if (reset)                                    err <= 1'b0;
    else if (state == VERIFY && drdata != dwdata) err <= 1'b1;
  end
`else
  logic unused_drdata;
  assign unused_drdata = ^drdata;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_diary_mem_writer.sv
// Directed bench for diary_mem_writer: expected writes are queued as bytes are sent and
// compared against the writes seen on the memory bus, plus direct checks of status outputs.
module tb_diary_mem_writer;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [11:0] wr_ptr;
  logic [12:0] word_count;
  logic        full;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];
  logic [67:0] exp_q [$];
  logic [67:0] obs_q [$];
  int          rd_idx = 0;

  // bench model of the packer
  logic [31:0] m_pack = 32'h0;
  int          m_lane = 0;
  int          m_ptr  = 0;

  always #5 clk = ~clk;

  diary_mem_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata),
    .wr_ptr(wr_ptr), .word_count(word_count), .full(full), .err(err)
  );

  // Memory model: writes at the clock edge, combinational read.
  always @(posedge clk) if (dwe == 4'hF) mem[daddr[11:0]] <= dwdata;
  assign drdata = mem[daddr[11:0]];

  // Record every bus cycle with any byte enable set.
  always @(negedge clk) if (dwe !== 4'h0) obs_q.push_back({daddr, dwdata, dwe});

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input bit last);
    m_pack = m_pack | ({24'h0, d} << (8 * m_lane));
    m_lane++;
    if (last || m_lane == 4) begin
      exp_q.push_back({BASE | 32'(m_ptr), m_pack, 4'hF});
      m_ptr  = (m_ptr + 1) % 4096;
      m_pack = 32'h0;
      m_lane = 0;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit last, output time t_acc);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("send_timeout", 68'(n), 68'(0));
      t_acc = 0;
    end else begin
      @(posedge clk);
      t_acc = $time;
      model_byte(d, last);
    end
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    logic [67:0] e;
    chk({tag, "_count"}, 68'(obs_q.size() - rd_idx), 68'(exp_q.size()));
    while (rd_idx < obs_q.size() && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_write"}, obs_q[rd_idx], e);
      rd_idx++;
    end
    rd_idx = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    time t0, t1, tx;
    int  nobs;
    logic [7:0] bytes8 [8];
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0;
    cycles(3);
    @(negedge clk);
    chk("rst_daddr", 68'(daddr), 68'(BASE));
    chk("rst_dwdata", 68'(dwdata), 68'(0));
    chk("rst_dwe", 68'(dwe), 68'(0));
    chk("rst_ptr_cnt", 68'({wr_ptr, word_count}), 68'(0));
    chk("rst_full_err", 68'({full, err}), 68'(0));
    chk("rst_ready", 68'(in_ready), 68'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 68'(in_ready), 68'(1));

    // "Hello" word: full 4-byte pack
    @(posedge clk); #1;
    send(8'h48, 1'b0, tx);
    send(8'h65, 1'b0, tx);
    send(8'h6C, 1'b0, tx);
    send(8'h6F, 1'b0, tx);
    chk("hello_dwe_n1", 68'(dwe), 68'(4'hF));
    chk("hello_ready_n1", 68'(in_ready), 68'(0));
    chk("hello_dwdata", 68'(dwdata), 68'(32'h6F6C_6548));
    chk("hello_daddr", 68'(daddr), 68'(32'h0001_0000));
    cycles(1);
    chk("hello_dwe_n2", 68'(dwe), 68'(0));
    chk("hello_ready_n2", 68'(in_ready), 68'(1));
    chk("hello_ptr", 68'(wr_ptr), 68'(1));
    chk("hello_cnt", 68'(word_count), 68'(1));
    chk("hello_mem", 68'(mem[0]), 68'(32'h6F6C_6548));
    drain("hello");

    // Short entry flushed by in_last, then a one-byte entry starting at lane 0
    send(8'h41, 1'b0, tx);
    send(8'h42, 1'b1, tx);
    cycles(2);
    send(8'h5A, 1'b1, tx);
    cycles(2);
    chk("flush_mem1", 68'(mem[1]), 68'(32'h0000_4241));
    chk("flush_mem2", 68'(mem[2]), 68'(32'h0000_005A));
    chk("flush_ptr", 68'(wr_ptr), 68'(3));
    drain("flush");

    // Back-to-back bytes: one bubble after every 4th byte
    bytes8 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    send(bytes8[0], 1'b0, t0);
    for (int i = 1; i < 8; i++) send(bytes8[i], 1'b0, t1);
    chk("stream_span_ns", 68'(t1 - t0), 68'(80));
    cycles(2);
    chk("stream_ptr", 68'(wr_ptr), 68'(5));
    drain("stream");

    // Reset during the write cycle: the write lands, then state returns to reset values
    send(8'hA1, 1'b0, tx);
    send(8'hB2, 1'b0, tx);
    send(8'hC3, 1'b0, tx);
    send(8'hD4, 1'b0, tx);
    chk("rstmid_dwe", 68'(dwe), 68'(4'hF));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_dwe_after", 68'(dwe), 68'(0));
    chk("rstmid_ptr", 68'(wr_ptr), 68'(0));
    chk("rstmid_cnt", 68'(word_count), 68'(0));
    chk("rstmid_mem", 68'(mem[5]), 68'(32'hD4C3_B2A1));
    drain("rstmid");
    m_ptr = 0; m_lane = 0; m_pack = 32'h0;

    // Fill the whole memory with one-byte entries
    for (int i = 0; i < 4095; i++) send(8'(i), 1'b1, tx);
    cycles(2);
    chk("fill_not_full", 68'({full, word_count}), 68'({1'b0, 13'd4095}));
    send(8'hEE, 1'b1, tx);
    cycles(2);
    chk("fill_full", 68'(full), 68'(1));
    chk("fill_cnt", 68'(word_count), 68'(4096));
    chk("fill_ready", 68'(in_ready), 68'(0));
    chk("fill_ptr_wrap", 68'(wr_ptr), 68'(0));
    chk("fill_last_mem", 68'(mem[4095]), 68'(32'h0000_00EE));
    drain("fill");

    // Further traffic while full must not produce any write
    nobs = obs_q.size();
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    cycles(10);
    in_valid = 1'b0; in_last = 1'b0;
    chk("full_no_write", 68'(obs_q.size()), 68'(nobs));
    chk("full_still_ready0", 68'(in_ready), 68'(0));

    // Reset clears full
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_clears_full", 68'({full, in_ready}), 68'({1'b0, 1'b1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
